// File: rtl/ctrlr_pkg.sv
// rtl/ctrlr_pkg.sv - shared states, command fields and map constants for spi_regbank_ctrlr
package ctrlr_pkg;

   typedef enum logic [1:0] {ST_CMD, ST_READ, ST_WRITE} state_t;

   localparam int CMD_RW      = 7;
   localparam int CMD_INC     = 6;
   localparam int CMD_ADDR_HI = 5;
   localparam int CMD_ADDR_LO = 0;

   localparam logic [5:0] ADDR_CHIP_ID = 6'd0;
   localparam logic [5:0] ADDR_STATUS  = 6'd63;
   localparam logic [7:0] RD_UNMAPPED  = 8'hFF;

   function automatic int bytes_of(input int bits);
      return (bits + 7) / 8;
   endfunction

endpackage

// File: rtl/regbank_rd_mux.sv
// rtl/regbank_rd_mux.sv - byte read mux holding the whole address map decode
// Status register at address 63 exists only with CTRLR_STATUS_EN defined.
module regbank_rd_mux
   import ctrlr_pkg::*;
#(
   parameter int         SW_W    = 16,
   parameter int         LED_W   = 16,
   parameter logic [7:0] CHIP_ID = 8'h07
) (
   input  logic [5:0]       addr,
   input  logic [SW_W-1:0]  switches,
   input  logic [LED_W-1:0] leds,
`ifdef CTRLR_STATUS_EN
   input  logic [7:0]       status,
   output logic             unmapped,
`endif
   output logic [7:0]       rd
);

   localparam int SW_B  = bytes_of(SW_W);
   localparam int LED_B = bytes_of(LED_W);

   logic [SW_B*8-1:0]  sw_pad;
   logic [LED_B*8-1:0] led_pad;
   logic               hit;

   // Padding bits above SW_W/LED_W read back as zero.
   always_comb begin
      sw_pad              = '0;
      sw_pad[SW_W-1:0]    = switches;
      led_pad             = '0;
      led_pad[LED_W-1:0]  = leds;
      rd                  = 8'h00;
      hit                 = 1'b0;
      if (addr == ADDR_CHIP_ID) begin
         rd  = CHIP_ID;
         hit = 1'b1;
      end
      for (int k = 0; k < SW_B; k++) begin
         if (addr == 6'(k + 1)) begin
            rd  = sw_pad[8*k +: 8];
            hit = 1'b1;
         end
      end
      for (int k = 0; k < LED_B; k++) begin
         if (addr == 6'(SW_B + 1 + k)) begin
            rd  = led_pad[8*k +: 8];
            hit = 1'b1;
         end
      end
`ifdef CTRLR_STATUS_EN
      if (addr == ADDR_STATUS) begin
         rd  = status;
         hit = 1'b1;
      end
`endif
      if (!hit) rd = RD_UNMAPPED;
   end

`ifdef CTRLR_STATUS_EN
   assign unmapped = ~hit;
`endif

endmodule

// File: rtl/spi_regbank_ctrlr.sv
// rtl/spi_regbank_ctrlr.sv - SPI byte-stream MMIO register bank: chip ID, switches, LEDs
// Optional status register at address 63 enabled by CTRLR_STATUS_EN.
module spi_regbank_ctrlr
   import ctrlr_pkg::*;
#(
   parameter int         SW_W    = 16,
   parameter int         LED_W   = 16,
   parameter logic [7:0] CHIP_ID = 8'h07
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SW_W-1:0]  switches,
   output logic [LED_W-1:0] leds,
   input  logic             frame_act,
   input  logic             new_data,
   input  logic [7:0]       din,
   output logic [7:0]       dout
);

   localparam int SW_B   = bytes_of(SW_W);
   localparam int LED_B  = bytes_of(LED_W);
   localparam int LED_LO = SW_B + 1;
   localparam int LED_HI = SW_B + LED_B;

   generate
      if (1 + SW_B + LED_B > 63) begin : g_map_too_big
         $error("spi_regbank_ctrlr: switch and LED bytes do not fit the 6-bit map");
      end
   endgenerate

   state_t           state_q, state_d;
   logic [5:0]       addr_q, addr_d;
   logic             inc_q, inc_d;
   logic [7:0]       dout_d;
   logic [5:0]       rd_addr;
   logic [7:0]       rd_byte;
   logic             rd_load;
   logic             wr_en;
   logic             wr_hit;
   logic [LED_W-1:0] leds_d;

   // The mux looks ahead to the address the current byte will land on.
   assign rd_addr = (state_q == ST_CMD)              ? din[CMD_ADDR_HI:CMD_ADDR_LO] :
                    (state_q == ST_READ && inc_q)    ? addr_q + 6'd1 : addr_q;

   assign wr_hit = (addr_q >= 6'(LED_LO)) && (addr_q <= 6'(LED_HI));

`ifdef CTRLR_STATUS_EN
   logic [7:0] status_q;
   logic       rd_unmapped;
   logic       st_clr;
   logic       bad_evt;
   logic       cmd_evt;

   regbank_rd_mux #(.SW_W(SW_W), .LED_W(LED_W), .CHIP_ID(CHIP_ID)) u_rd_mux (
      .addr     (rd_addr),
      .switches (switches),
      .leds     (leds),
      .status   (status_q),
      .unmapped (rd_unmapped),
      .rd       (rd_byte)
   );

   assign cmd_evt = frame_act & new_data & (state_q == ST_CMD);
   assign bad_evt = (rd_load & rd_unmapped) | (wr_en & ~wr_hit);
   assign st_clr  = rd_load & (rd_addr == ADDR_STATUS);

   // Clear-on-read, but an event in the same cycle survives the clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         status_q <= '0;
      end else begin
         status_q[7]   <= (status_q[7] & ~st_clr) | bad_evt;
         status_q[6:0] <= (st_clr ? 7'd0 : status_q[6:0]) + {6'd0, cmd_evt};
      end
   end
`else
   regbank_rd_mux #(.SW_W(SW_W), .LED_W(LED_W), .CHIP_ID(CHIP_ID)) u_rd_mux (
      .addr     (rd_addr),
      .switches (switches),
      .leds     (leds),
      .rd       (rd_byte)
   );
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      inc_d   = inc_q;
      dout_d  = dout;
      rd_load = 1'b0;
      wr_en   = 1'b0;
      if (!frame_act) begin
         state_d = ST_CMD;
         dout_d  = CHIP_ID;
      end else if (new_data) begin
         case (state_q)
            ST_CMD: begin
               addr_d = din[CMD_ADDR_HI:CMD_ADDR_LO];
               inc_d  = din[CMD_INC];
               if (din[CMD_RW]) begin
                  state_d = ST_READ;
                  dout_d  = rd_byte;
                  rd_load = 1'b1;
               end else begin
                  state_d = ST_WRITE;
                  dout_d  = CHIP_ID;
               end
            end
            ST_READ: begin
               addr_d  = rd_addr;
               dout_d  = rd_byte;
               rd_load = 1'b1;
            end
            ST_WRITE: begin
               wr_en  = 1'b1;
               if (inc_q) addr_d = addr_q + 6'd1;
               dout_d = CHIP_ID;
            end
            default: state_d = ST_CMD;
         endcase
      end
   end

   // Only bits that exist in the LED vector are written; padding is dropped.
   always_comb begin
      leds_d = leds;
      for (int i = 0; i < LED_W; i++) begin
         if (addr_q == 6'(LED_LO + i / 8)) leds_d[i] = din[i % 8];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_CMD;
         addr_q  <= '0;
         inc_q   <= 1'b0;
         dout    <= CHIP_ID;
         leds    <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         inc_q   <= inc_d;
         dout    <= dout_d;
         if (wr_en && wr_hit) leds <= leds_d;
      end
   end

endmodule

// File: tb/tb_spi_regbank_ctrlr.sv
// tb/tb_spi_regbank_ctrlr.sv - scoreboard bench for spi_regbank_ctrlr (SW_W=16, LED_W=12)
module tb_spi_regbank_ctrlr;

   localparam int SW_W  = 16;
   localparam int LED_W = 12;

   logic             clk = 1'b0;
   logic             rst;
   logic [SW_W-1:0]  switches;
   logic [LED_W-1:0] leds;
   logic             frame_act;
   logic             new_data;
   logic [7:0]       din;
   logic [7:0]       dout;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   spi_regbank_ctrlr #(.SW_W(SW_W), .LED_W(LED_W), .CHIP_ID(8'h07)) dut (
      .clk       (clk),
      .rst       (rst),
      .switches  (switches),
      .leds      (leds),
      .frame_act (frame_act),
      .new_data  (new_data),
      .din       (din),
      .dout      (dout)
   );

   // One received byte: expected dout is queued, then popped once the byte has taken effect.
   task automatic xfer(input logic [7:0] b, input logic [7:0] exp, input string name);
      logic [7:0] e;
      exp_q.push_back(exp);
      @(negedge clk);
      din      = b;
      new_data = 1'b1;
      @(negedge clk);
      new_data = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if (dout !== e) begin
         n_bad++;
         $display("FAIL %s: dout=%02h required %02h", name, dout, e);
      end
      @(negedge clk);
      n_cmp++;
      if (dout !== e) begin
         n_bad++;
         $display("FAIL %s_hold: dout=%02h required %02h", name, dout, e);
      end
   endtask

   task automatic begin_frame();
      @(negedge clk);
      frame_act = 1'b1;
   endtask

   task automatic end_frame(input string name);
      @(negedge clk);
      frame_act = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (dout !== 8'h07) begin
         n_bad++;
         $display("FAIL %s_idle: dout=%02h required 07", name, dout);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (leds !== 12'h000 || dout !== 8'h07) begin
         n_bad++;
         $display("FAIL reset: leds=%03h dout=%02h required 000/07", leds, dout);
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_burst_read();
      switches = 16'hBEEF;
      begin_frame();
      xfer(8'hC0, 8'h07, "rd_cmd");
      xfer(8'h00, 8'hEF, "rd_b1");
      xfer(8'h00, 8'hBE, "rd_b2");
      xfer(8'h00, 8'h00, "rd_b3");
      end_frame("rd");
   endtask

   task automatic test_burst_write();
      begin_frame();
      xfer(8'h43, 8'h07, "wr_cmd");
      xfer(8'hA5, 8'h07, "wr_b1");
      xfer(8'hFF, 8'h07, "wr_b2");
      end_frame("wr");
      n_cmp++;
      if (leds !== 12'hFA5) begin
         n_bad++;
         $display("FAIL wr_leds: leds=%03h required FA5", leds);
      end
      begin_frame();
      xfer(8'hC3, 8'hA5, "rb_lo");
      xfer(8'h00, 8'h0F, "rb_hi");
      xfer(8'h00, 8'hFF, "rb_unmapped");
      end_frame("rb");
   endtask

   task automatic test_no_inc();
      switches = 16'h0012;
      begin_frame();
      xfer(8'h81, 8'h12, "noinc_cmd");
      switches = 16'h0034;
      xfer(8'h00, 8'h34, "noinc_b1");
      switches = 16'hFF56;
      xfer(8'h00, 8'h56, "noinc_b2");
      end_frame("noinc");
   endtask

   task automatic test_abort_unmapped();
      begin_frame();
      xfer(8'h43, 8'h07, "abort_cmd");
      end_frame("abort");
      n_cmp++;
      if (leds !== 12'hFA5) begin
         n_bad++;
         $display("FAIL abort_leds: leds=%03h required FA5", leds);
      end
      @(negedge clk);
      din      = 8'hC3;
      new_data = 1'b1;
      @(negedge clk);
      new_data = 1'b0;
      begin_frame();
      xfer(8'hC3, 8'hA5, "after_abort");
      end_frame("after_abort");
      begin_frame();
      xfer(8'h90, 8'hFF, "unmapped_rd");
      xfer(8'h00, 8'hFF, "unmapped_inc");
      end_frame("unmapped");
   endtask

   task automatic test_reset_midburst();
      switches = 16'hBEEF;
      begin_frame();
      xfer(8'h43, 8'h07, "mid_cmd");
      xfer(8'h5A, 8'h07, "mid_b1");
      n_cmp++;
      if (leds !== 12'hF5A) begin
         n_bad++;
         $display("FAIL mid_leds: leds=%03h required F5A", leds);
      end
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if (leds !== 12'h000 || dout !== 8'h07) begin
         n_bad++;
         $display("FAIL mid_reset: leds=%03h dout=%02h required 000/07", leds, dout);
      end
      @(negedge clk);
      rst = 1'b1;
      xfer(8'hC1, 8'hEF, "post_reset_cmd");
      end_frame("post_reset");
   endtask

`ifdef CTRLR_STATUS_EN
   task automatic test_status();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      switches = 16'hBEEF;
      begin_frame();
      xfer(8'hC1, 8'hEF, "st_f1_cmd");
      xfer(8'h00, 8'hBE, "st_f1_b1");
      end_frame("st_f1");
      begin_frame();
      xfer(8'h90, 8'hFF, "st_f2_bad");
      end_frame("st_f2");
      begin_frame();
      xfer(8'h43, 8'h07, "st_f3_cmd");
      xfer(8'h5A, 8'h07, "st_f3_b1");
      end_frame("st_f3");
      begin_frame();
      xfer(8'hBF, 8'h83, "st_read");
      xfer(8'h00, 8'h01, "st_reread");
      xfer(8'h00, 8'h00, "st_cleared");
      end_frame("st_f4");
   endtask
`else
   task automatic test_wrap();
      switches = 16'hBEEF;
      begin_frame();
      xfer(8'hFF, 8'hFF, "wrap_63");
      xfer(8'h00, 8'h07, "wrap_0");
      xfer(8'h00, 8'hEF, "wrap_1");
      end_frame("wrap");
   endtask
`endif

   initial begin
      switches  = '0;
      frame_act = 1'b0;
      new_data  = 1'b0;
      din       = 8'h00;
      test_reset();
      test_burst_read();
      test_burst_write();
      test_no_inc();
      test_abort_unmapped();
      test_reset_midburst();
`ifdef CTRLR_STATUS_EN
      test_status();
`else
      test_wrap();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
